// File: rtl/cpu_pkg.sv
// Shared types for the LEGv8 pipeline: the decoded control bundle, the
// forwarding select encoding and the bubble helper.
package cpu_pkg;

  typedef struct packed {
    logic       reg2loc;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic [2:0] alu_op;
    logic       flag_wr_en;
    logic       rd_x30;
  } ctrl_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  localparam int XZR = 31;

  function automatic ctrl_t bubble_ctrl();
    return '0;
  endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// Compares one ID source index against the EX and MEM destinations and
// picks the operand source; also flags a hit on an in-flight load.
module fwd_unit
  import cpu_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_wreg,
  output fwd_sel_t         sel,
  output logic             load_hit
);

  localparam logic [REG_W-1:0] ZR = REG_W'(XZR);

  logic ex_match;
  logic mem_match;

  // XZR is never treated as a producer, so a write to it can't match.
  always_comb begin
    ex_match  = used && ex_reg_write && (ex_wreg != ZR) && (src == ex_wreg);
    mem_match = used && mem_reg_write && (mem_wreg != ZR) && (src == mem_wreg);
    load_hit  = ex_match && ex_mem_to_reg;
    if (ex_match && !ex_mem_to_reg) begin
      sel = FWD_MEM;
    end else if (mem_match) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer: carries the control bundle through EX/MEM/WB,
// stalls on load-use hazards and registers the EX forwarding selects.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  ctrl_t            id_ctrl,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_ra_used,
  input  logic             id_rb_used,
  input  logic [REG_W-1:0] id_wreg,
  input  logic             id_flag_br,
  output logic             stall,
  output ctrl_t            ex_ctrl,
  output ctrl_t            mem_ctrl,
  output ctrl_t            wb_ctrl,
  output logic [REG_W-1:0] ex_wreg,
  output logic [REG_W-1:0] mem_wreg,
  output logic [REG_W-1:0] wb_wreg,
  output fwd_sel_t         ex_fwd_a,
  output fwd_sel_t         ex_fwd_b,
  output logic             flag_fwd,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [REG_W-1:0] ZR = REG_W'(XZR);

  fwd_sel_t sel_a;
  fwd_sel_t sel_b;
  logic     hit_a;
  logic     hit_b;

  fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .src           (id_ra),
    .used          (id_ra_used),
    .ex_reg_write  (ex_ctrl.reg_write),
    .ex_mem_to_reg (ex_ctrl.mem_to_reg),
    .ex_wreg       (ex_wreg),
    .mem_reg_write (mem_ctrl.reg_write),
    .mem_wreg      (mem_wreg),
    .sel           (sel_a),
    .load_hit      (hit_a)
  );

  fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .src           (id_rb),
    .used          (id_rb_used),
    .ex_reg_write  (ex_ctrl.reg_write),
    .ex_mem_to_reg (ex_ctrl.mem_to_reg),
    .ex_wreg       (ex_wreg),
    .mem_reg_write (mem_ctrl.reg_write),
    .mem_wreg      (mem_wreg),
    .sel           (sel_b),
    .load_hit      (hit_b)
  );

  assign stall    = id_valid && (hit_a || hit_b);
  assign flag_fwd = id_valid && id_flag_br && ex_ctrl.flag_wr_en;

  // A stalled ID instruction is replayed next cycle, so EX takes a bubble now.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl   <= bubble_ctrl();
      mem_ctrl  <= bubble_ctrl();
      wb_ctrl   <= bubble_ctrl();
      ex_wreg   <= ZR;
      mem_wreg  <= ZR;
      wb_wreg   <= ZR;
      ex_fwd_a  <= FWD_RF;
      ex_fwd_b  <= FWD_RF;
      stall_cnt <= '0;
    end else begin
      wb_ctrl  <= mem_ctrl;
      wb_wreg  <= mem_wreg;
      mem_ctrl <= ex_ctrl;
      mem_wreg <= ex_wreg;
      if (id_valid && !stall) begin
        ex_ctrl  <= id_ctrl;
        ex_wreg  <= id_wreg;
        ex_fwd_a <= sel_a;
        ex_fwd_b <= sel_b;
      end else begin
        ex_ctrl  <= bubble_ctrl();
        ex_wreg  <= ZR;
        ex_fwd_a <= FWD_RF;
        ex_fwd_b <= FWD_RF;
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
